// File: rtl/mdu_pkg.sv
// mdu_pkg: shared FSM state, funct3 op codes and datapath sizes for the multiply/divide unit.
package mdu_pkg;
    localparam int XLEN     = 32;
    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one iteration, either shift-add multiply or restoring-divide, on the 64-bit accumulator.
module mdu_step
    import mdu_pkg::*;
(
    input  logic                div_i,
    input  logic [2*XLEN-1:0]   acc_i,
    input  logic [XLEN-1:0]     opb_i,
    output logic [2*XLEN-1:0]   acc_o
);
    logic [XLEN:0]   sum;
    logic [XLEN:0]   sh;
    logic [XLEN+1:0] sub;
    logic            ge;

    // Multiply: {hi, multiplier} shifts right, hi picks up the addend when the low bit is set.
    assign sum = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    // Divide: {rem, dividend} shifts left, the quotient bit enters at the bottom.
    assign sh  = acc_i[2*XLEN-1:XLEN-1];
    assign sub = {1'b0, sh} - {2'b0, opb_i};
    assign ge  = ~sub[XLEN+1];
    assign acc_o = div_i ? {(ge ? sub[XLEN-1:0] : sh[XLEN-1:0]), acc_i[XLEN-2:0], ge}
                         : {sum, acc_i[XLEN-1:1]};
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide sequencer (IDLE/CALC/FIX/DONE).
// Define MDU_EARLY_OUT_EN to finish zero-operand multiplies and zero-dividend divides in one cycle.
module mdu_sequencer
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, step_acc, prod;
    logic [XLEN-1:0]   opb_q, opb_d, res_q, res_d, a_mag, b_mag, quick_res, quo, rem;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d, rneg_q, rneg_d;
    logic              accept, a_neg, b_neg, quick;

    assign accept = state_q == IDLE && start_i && !flush_i;
    assign a_neg  = (op_i == MULH || op_i == MULHSU || op_i == DIV || op_i == REM) && rs1_i[XLEN-1];
    assign b_neg  = (op_i == MULH || op_i == DIV || op_i == REM) && rs2_i[XLEN-1];
    assign a_mag  = a_neg ? -rs1_i : rs1_i;
    assign b_mag  = b_neg ? -rs2_i : rs2_i;
    assign prod   = neg_q ? -acc_q : acc_q;
    assign quo    = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem    = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

    mdu_step u_step (
        .div_i (op_q[2]),
        .acc_i (acc_q),
        .opb_i (opb_q),
        .acc_o (step_acc)
    );

    // Cases resolved without iterating: divide by zero, signed overflow, optional zero early-out.
    always_comb begin
        quick     = 1'b0;
        quick_res = '0;
        if (op_i[2] && rs2_i == '0) begin
            quick     = 1'b1;
            quick_res = op_i[1] ? rs1_i : '1;
        end else if ((op_i == DIV || op_i == REM) && rs1_i == 32'h8000_0000 && rs2_i == '1) begin
            quick     = 1'b1;
            quick_res = op_i[1] ? '0 : 32'h8000_0000;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (op_i[2] ? rs1_i == '0 : (rs1_i == '0 || rs2_i == '0)) begin
            quick     = 1'b1;
            quick_res = '0;
        end
`else
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (accept) begin
                op_d    = op_i;
                state_d = quick ? DONE : CALC;
                res_d   = quick ? quick_res : res_q;
                cnt_d   = 5'(MDU_ITER - 1);
                acc_d   = {{XLEN{1'b0}}, a_mag};
                opb_d   = b_mag;
                neg_d   = a_neg ^ b_neg;
                rneg_d  = a_neg;
            end
            CALC: begin
                acc_d   = step_acc;
                cnt_d   = cnt_q - 5'd1;
                state_d = cnt_q == '0 ? FIX : CALC;
            end
            FIX: begin
                state_d = DONE;
                res_d   = op_q[2] ? (op_q[1] ? rem : quo)
                                  : (op_q == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

    assign busy_o   = state_q != IDLE;
    assign stall_o  = accept || state_q == CALC || state_q == FIX;
    assign done_o   = state_q == DONE;
    assign result_o = res_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed self-checking bench for mdu_sequencer (timing and results).
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] rs1_i, rs2_i, result_o;
    logic        busy_o, stall_o, done_o;
    int          n_chk = 0;
    int          n_fail = 0;
`ifdef MDU_EARLY_OUT_EN
    localparam int LAT_EO = 1;
`else
    localparam int LAT_EO = 34;
`endif

    mdu_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op at a negedge (cycle N) and measures cycles until done_o.
    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input logic [31:0] exp);
        int k;
        start_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b;
        #1 chk({tag, " stall@N"}, 32'(stall_o), 32'd1);
        @(negedge clk);
        start_i = 1'b0;
        k = 1;
        while (!done_o && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 32'(k), 32'(lat));
        chk({tag, " result"}, result_o, exp);
        @(negedge clk);
        chk({tag, " done pulse"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        bit ok;
        rst = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; rs1_i = '0; rs2_i = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy_o), 32'd0);
        chk("reset done", 32'(done_o), 32'd0);
        chk("reset result", result_o, 32'd0);
        chk("reset stall", 32'(stall_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MUL 7 x -3 with stall profile across N..N+33
        start_i = 1'b1; op_i = MUL; rs1_i = 32'd7; rs2_i = 32'hFFFF_FFFD;
        #1 chk("mul stall@N", 32'(stall_o), 32'd1);
        @(negedge clk);
        start_i = 1'b0;
        ok = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            if (!stall_o || done_o || !busy_o) ok = 1'b0;
            if (k < 33) @(negedge clk);
        end
        chk("mul stall N+1..N+33", 32'(ok), 32'd1);
        @(negedge clk);
        chk("mul done@N+34", 32'(done_o), 32'd1);
        chk("mul stall@N+34", 32'(stall_o), 32'd0);
        chk("mul result", result_o, 32'hFFFF_FFEB);
        @(negedge clk);
        chk("mul idle", 32'(busy_o), 32'd0);

        run("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE);
        run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 34, 32'hFFFF_FFFF);
        run("mulh", MULH, 32'hFFFF_FFFD, 32'd5, 34, 32'hFFFF_FFFF);
        run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        run("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD);
        run("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF);
        run("divu 100/7", DIVU, 32'd100, 32'd7, 34, 32'd14);
        run("remu 100/7", REMU, 32'd100, 32'd7, 34, 32'd2);
        run("divu /0", DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF);
        run("remu /0", REMU, 32'd5, 32'd0, 1, 32'd5);

        // Flush at N+10: idle at N+11, no done, result keeps 5
        start_i = 1'b1; op_i = DIVU; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush busy", 32'(busy_o), 32'd0);
        ok = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (done_o || busy_o) ok = 1'b0;
            @(negedge clk);
        end
        chk("flush no done", 32'(ok), 32'd1);
        chk("flush result", result_o, 32'd5);

        // Flush beats start in IDLE
        start_i = 1'b1; flush_i = 1'b1; op_i = MUL; rs1_i = 32'd3; rs2_i = 32'd3;
        #1 chk("flush>start stall", 32'(stall_o), 32'd0);
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        chk("flush>start busy", 32'(busy_o), 32'd0);

        run("mul zero", MUL, 32'd0, 32'h123, LAT_EO, 32'd0);
        run("divu 9/4", DIVU, 32'd9, 32'd4, 34, 32'd2);

        // Reset at N+5 discards the op
        start_i = 1'b1; op_i = MULHU; rs1_i = 32'd11; rs2_i = 32'd13;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst stall", 32'(stall_o), 32'd0);
        chk("rst result", result_o, 32'd0);
        ok = 1'b1;
        for (int k = 0; k < 35; k++) begin
            if (done_o) ok = 1'b0;
            @(negedge clk);
        end
        chk("rst no done", 32'(ok), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
